// File: rtl/l1_ahb_mtx_pkg.sv
// Shared AHB encodings, arbiter state enum and burst-length helper for the L1 bus matrix.
package l1_ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_NOPORT = 2'd0,
    ST_OWNED  = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_st_e;

  // Beats in a fixed-length burst; 1 for SINGLE and undefined-length INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   burst_beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/l1_ahb_mtx_rr_pick.sv
// Combinational round-robin picker: first requester after last_ptr wins, last_ptr itself competes last.
module l1_ahb_mtx_rr_pick #(
  parameter int NUM_IN = 3,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  last_ptr,
  output logic [NUM_IN-1:0] winner,
  output logic              any
);

  // Rotating search starting one past the last grant.
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(last_ptr) + k) % NUM_IN;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/l1_ahb_mtx_out_arb.sv
// Output-port arbiter of the L1 AHB matrix: round-robin grant, held across fixed bursts and locked sequences.
module l1_ahb_mtx_out_arb
  import l1_ahb_mtx_pkg::*;
#(
  parameter int NUM_IN = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_IN-1:0]     sel_op,
  input  logic [2*NUM_IN-1:0]   trans_op,
  input  logic [3*NUM_IN-1:0]   burst_op,
  input  logic [NUM_IN-1:0]     mastlock_op,
  input  logic                  HREADYM,
  output logic [NUM_IN-1:0]     addr_in_port,
  output logic                  no_port,
  output logic [NUM_IN-1:0]     data_in_port,
  output logic [NUM_IN-1:0]     active,
  output logic                  hmastlock_out
);

  localparam int PTR_W = $clog2(NUM_IN);

  arb_st_e           st_q, st_d;
  logic [NUM_IN-1:0] own_q, own_d, data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]  last_q, last_d;

  logic [NUM_IN-1:0] req, winner;
  logic              any;
  logic [1:0]        own_trans;
  logic [2:0]        own_burst;
  logic              own_lock;
  logic [4:0]        own_beats;
  logic              rearb, cnt_dec;

  // An input requests this output when selected and issuing NONSEQ or SEQ.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) req[i] = sel_op[i] & trans_op[2*i+1];
  end

  l1_ahb_mtx_rr_pick #(.NUM_IN(NUM_IN), .PTR_W(PTR_W)) u_pick (
    .req      (req),
    .last_ptr (last_q),
    .winner   (winner),
    .any      (any)
  );

  // Owner's transfer attributes; a deselected owner looks like IDLE without lock.
  always_comb begin
    own_trans = HTRANS_IDLE;
    own_burst = HBURST_SINGLE;
    own_lock  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (own_q[i] && sel_op[i]) begin
        own_trans = trans_op[2*i +: 2];
        own_burst = burst_op[3*i +: 3];
        own_lock  = mastlock_op[i];
      end
    end
    own_beats = burst_beats(own_burst);
  end

  // Next-state: everything advances only when the output transfer completes.
  always_comb begin
    st_d    = st_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    rearb   = 1'b0;
    cnt_dec = 1'b0;
    if (HREADYM) begin
      data_d = own_trans[1] ? own_q : '0;
      if (st_q == ST_NOPORT) begin
        rearb = 1'b1;
      end else if (own_trans == HTRANS_NONSEQ && own_beats > 5'd1) begin
        st_d  = ST_BURST;
        cnt_d = 4'(own_beats - 5'd1);
      end else if (st_q == ST_BURST && own_trans == HTRANS_SEQ && cnt_q != 4'd1) begin
        cnt_d   = cnt_q - 4'd1;
        cnt_dec = 1'b1;
      end else if (st_q == ST_BURST && own_trans == HTRANS_BUSY) begin
        cnt_d = cnt_q;
      end else begin
        // Single beat done, burst finished or cut short, or lock released.
        cnt_d = 4'd0;
        if (own_lock) st_d = ST_LOCKED;
        else          rearb = 1'b1;
      end
      if (rearb) begin
        if (any) begin
          st_d  = ST_OWNED;
          own_d = winner;
          for (int i = 0; i < NUM_IN; i++) if (winner[i]) last_d = PTR_W'(i);
        end else begin
          st_d  = ST_NOPORT;
          own_d = '0;
        end
      end
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st_q   <= ST_NOPORT;
      own_q  <= '0;
      data_q <= '0;
      cnt_q  <= 4'd0;
      last_q <= PTR_W'(NUM_IN - 1);
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign addr_in_port  = own_q;
  assign active        = own_q;
  assign no_port       = (st_q == ST_NOPORT);
  assign data_in_port  = data_q;
  assign hmastlock_out = |(own_q & mastlock_op);

  // The beat counter must never wrap below zero.
  a_cnt_no_underflow: assert property (@(posedge HCLK) disable iff (HRESET) cnt_dec |-> cnt_q != 4'd0);

endmodule

// File: tb/tb_l1_ahb_mtx_out_arb.sv
// Bench for l1_ahb_mtx_out_arb: hand vectors for the corner sequences, then random traffic against a model.
module tb_l1_ahb_mtx_out_arb;

  localparam int N = 3;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic [N-1:0]   sel_op, mastlock_op;
  logic [2*N-1:0] trans_op;
  logic [3*N-1:0] burst_op;
  logic           HREADYM;
  logic [N-1:0]   addr_in_port, data_in_port, active;
  logic           no_port, hmastlock_out;

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_out_arb #(.NUM_IN(N)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .sel_op(sel_op), .trans_op(trans_op),
    .burst_op(burst_op), .mastlock_op(mastlock_op), .HREADYM(HREADYM),
    .addr_in_port(addr_in_port), .no_port(no_port), .data_in_port(data_in_port),
    .active(active), .hmastlock_out(hmastlock_out)
  );

  typedef struct {
    logic       rst, rdy;
    logic [2:0] sel, lock;
    logic [5:0] trans;
    logic [8:0] burst;
    logic [2:0] e_addr, e_data;
    logic       e_nop, e_hml;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 none), beats still owed in a fixed burst, rr pointer, data owner.
  int m_own = -1, m_rem = 0, m_last = N - 1, m_data = -1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int blen(input int b);
    if (b < 2) return 1;
    return 4 << ((b - 2) / 2);
  endfunction

  function automatic int rr_win();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (sel_op[idx] && trans_op[2*idx+1]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] oh(input int i);
    logic [7:0] r;
    r = 8'd0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int t, b, w, nd;
    bit lk, rearb;
    if (HRESET) begin
      m_own = -1; m_rem = 0; m_last = N - 1; m_data = -1;
      return;
    end
    if (!HREADYM) return;
    nd = -1;
    rearb = 0;
    if (m_own < 0) rearb = 1;
    else begin
      t  = sel_op[m_own] ? int'(trans_op[2*m_own +: 2]) : 0;
      lk = sel_op[m_own] & mastlock_op[m_own];
      b  = int'(burst_op[3*m_own +: 3]);
      if (t >= 2) nd = m_own;
      if (t == 2 && blen(b) > 1) m_rem = blen(b) - 1;
      else begin
        if (m_rem > 0) begin
          if (t == 3) m_rem--;
          else if (t != 1) m_rem = 0;
        end
        if (m_rem == 0 && !lk) rearb = 1;
      end
    end
    if (rearb) begin
      w = rr_win();
      m_own = w;
      if (w >= 0) m_last = w;
    end
    m_data = nd;
  endtask

  task automatic check_model();
    logic [7:0] e_hml;
    e_hml = (m_own >= 0) ? {7'd0, mastlock_op[m_own]} : 8'd0;
    chk("m_addr",   {5'd0, addr_in_port}, oh(m_own));
    chk("m_active", {5'd0, active},       oh(m_own));
    chk("m_data",   {5'd0, data_in_port}, oh(m_data));
    chk("m_noport", {7'd0, no_port},      {7'd0, m_own < 0});
    chk("m_hml",    {7'd0, hmastlock_out}, e_hml);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [2:0] sel, input logic [5:0] tr,
                       input logic [8:0] bu, input logic [2:0] lk);
    HRESET = rst; HREADYM = rdy; sel_op = sel; trans_op = tr; burst_op = bu; mastlock_op = lk;
    @(posedge HCLK);
    #1;
    model_edge();
    check_model();
  endtask

  task automatic add(input logic rst, input logic rdy, input logic [2:0] sel, input logic [5:0] tr,
                     input logic [8:0] bu, input logic [2:0] lk, input logic [2:0] ea,
                     input logic [2:0] ed, input logic en, input logic eh);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.sel = sel; v.trans = tr; v.burst = bu; v.lock = lk;
    v.e_addr = ea; v.e_data = ed; v.e_nop = en; v.e_hml = eh;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t cur;
    logic [5:0] tr;
    HRESET = 1'b1; HREADYM = 1'b1; sel_op = '0; trans_op = '0; burst_op = '0; mastlock_op = '0;

    // A: round-robin of NONSEQ SINGLE from all three inputs, data one transfer behind.
    add(1,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b111,6'b101010,9'o000,3'b000, 3'b001,3'b000,0,0);
    add(0,1,3'b111,6'b101010,9'o000,3'b000, 3'b010,3'b001,0,0);
    add(0,1,3'b111,6'b101010,9'o000,3'b000, 3'b100,3'b010,0,0);
    add(0,1,3'b111,6'b101010,9'o000,3'b000, 3'b001,3'b100,0,0);
    // B: input 1 INCR4 (NONSEQ + 3 SEQ with 2 BUSY inside) while input 0 waits.
    add(1,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b010,6'b001000,9'o030,3'b000, 3'b010,3'b000,0,0);
    add(0,1,3'b011,6'b001010,9'o030,3'b000, 3'b010,3'b010,0,0);
    add(0,1,3'b011,6'b001110,9'o030,3'b000, 3'b010,3'b010,0,0);
    add(0,1,3'b011,6'b000110,9'o030,3'b000, 3'b010,3'b000,0,0);
    add(0,1,3'b011,6'b000110,9'o030,3'b000, 3'b010,3'b000,0,0);
    add(0,1,3'b011,6'b001110,9'o030,3'b000, 3'b010,3'b010,0,0);
    add(0,1,3'b011,6'b001110,9'o030,3'b000, 3'b001,3'b010,0,0);
    add(0,1,3'b001,6'b000010,9'o000,3'b000, 3'b001,3'b001,0,0);
    // C: input 2 WRAP8 cut by IDLE after 3 beats, nobody else asking.
    add(1,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b100,6'b100000,9'o400,3'b000, 3'b100,3'b000,0,0);
    add(0,1,3'b100,6'b100000,9'o400,3'b000, 3'b100,3'b100,0,0);
    add(0,1,3'b100,6'b110000,9'o400,3'b000, 3'b100,3'b100,0,0);
    add(0,1,3'b100,6'b110000,9'o400,3'b000, 3'b100,3'b100,0,0);
    add(0,1,3'b100,6'b000000,9'o400,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b100,6'b000000,9'o400,3'b000, 3'b000,3'b000,1,0);
    // D: input 0 locked for 5 beats (incl. IDLE and BUSY), input 1 requesting throughout.
    add(1,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b011,6'b001010,9'o000,3'b001, 3'b001,3'b000,0,1);
    add(0,1,3'b011,6'b001010,9'o000,3'b001, 3'b001,3'b001,0,1);
    add(0,1,3'b011,6'b001000,9'o000,3'b001, 3'b001,3'b000,0,1);
    add(0,1,3'b011,6'b001001,9'o000,3'b001, 3'b001,3'b000,0,1);
    add(0,1,3'b011,6'b001010,9'o000,3'b001, 3'b001,3'b001,0,1);
    add(0,1,3'b011,6'b001010,9'o000,3'b001, 3'b001,3'b001,0,1);
    add(0,1,3'b011,6'b001000,9'o000,3'b000, 3'b010,3'b000,0,0);
    add(0,1,3'b010,6'b001000,9'o000,3'b000, 3'b010,3'b010,0,0);
    // E: INCR8 on input 0, HREADYM low 4 cycles, then reset mid-burst.
    add(1,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b001,6'b000010,9'o005,3'b000, 3'b001,3'b000,0,0);
    add(0,1,3'b001,6'b000010,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,1,3'b001,6'b000011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,1,3'b001,6'b000011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,0,3'b001,6'b000011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,0,3'b001,6'b000000,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,0,3'b011,6'b001011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,0,3'b001,6'b000011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(0,1,3'b001,6'b000011,9'o005,3'b000, 3'b001,3'b001,0,0);
    add(1,1,3'b001,6'b000011,9'o005,3'b000, 3'b000,3'b000,1,0);
    add(0,1,3'b000,6'b000000,9'o000,3'b000, 3'b000,3'b000,1,0);

    @(negedge HCLK);
    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i];
      drive(cur.rst, cur.rdy, cur.sel, cur.trans, cur.burst, cur.lock);
      chk($sformatf("v%0d_addr", i),   {5'd0, addr_in_port},  {5'd0, cur.e_addr});
      chk($sformatf("v%0d_active", i), {5'd0, active},        {5'd0, cur.e_addr});
      chk($sformatf("v%0d_data", i),   {5'd0, data_in_port},  {5'd0, cur.e_data});
      chk($sformatf("v%0d_noport", i), {7'd0, no_port},       {7'd0, cur.e_nop});
      chk($sformatf("v%0d_hml", i),    {7'd0, hmastlock_out}, {7'd0, cur.e_hml});
    end

    // Random traffic, SEQ-heavy so fixed bursts actually run, with sparse locks and resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        tr[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
      end
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), tr,
            9'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
